// File: rtl/dds_phase_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dds_phase_gen                                                 |
// | Purpose  : DDS control registers, phase accumulator and wave memory      |
// |            read pipeline with continuous or N-sample burst operation.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dds_phase_gen #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int PHASE_WIDTH    = 32,
  parameter int LUT_ADDR_WIDTH = 10,
  parameter int WAVE_WIDTH     = 16
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_n_i,
  input  logic                      map_wr_en_i,
  input  logic [ADDR_WIDTH-1:0]     map_wr_addr_i,
  input  logic [DATA_WIDTH-1:0]     map_wr_dat_i,
  output logic                      mem_rd_en_o,
  output logic [LUT_ADDR_WIDTH-1:0] mem_rd_addr_o,
  input  logic [WAVE_WIDTH-1:0]     mem_rd_dat_i,
  output logic [WAVE_WIDTH-1:0]     wave_o,
  output logic                      wave_valid_o,
  output logic                      sync_o,
  output logic                      done_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] C_A_CTRL = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] C_A_INC  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] C_A_OFS  = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] C_A_LEN  = ADDR_WIDTH'(3);

  logic [1:0]                state_q, state_d;
  logic                      run_q, run_d;
  logic [PHASE_WIDTH-1:0]    pending_inc_q;
  logic [PHASE_WIDTH-1:0]    active_inc_q, active_inc_d;
  logic [PHASE_WIDTH-1:0]    ofs_q;
  logic [DATA_WIDTH-1:0]     burst_len_q;
  logic [DATA_WIDTH-1:0]     burst_cnt_q, burst_cnt_d;
  logic [PHASE_WIDTH-1:0]    acc_q, acc_d;
  logic                      wrap_q, wrap_d;
  logic                      rd_en_q, rd_en_d;
  logic [LUT_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                      sync_q, sync_d;
  logic                      rd_pend_q;
  logic [WAVE_WIDTH-1:0]     wave_q;
  logic                      wave_valid_q;
  logic                      done_q, done_d;

  logic                      w_wr_ctrl;
  logic                      w_wr_inc;
  logic                      w_wr_ofs;
  logic                      w_wr_len;
  logic                      w_clr;
  logic                      w_carry;
  logic                      w_wrap;
  logic [PHASE_WIDTH-1:0]    w_acc_sum;
  logic [PHASE_WIDTH-1:0]    w_phase;
  logic                      w_last;

  assign w_wr_ctrl = map_wr_en_i && (map_wr_addr_i == C_A_CTRL);
  assign w_wr_inc  = map_wr_en_i && (map_wr_addr_i == C_A_INC);
  assign w_wr_ofs  = map_wr_en_i && (map_wr_addr_i == C_A_OFS);
  assign w_wr_len  = map_wr_en_i && (map_wr_addr_i == C_A_LEN);
  assign w_clr     = w_wr_ctrl && map_wr_dat_i[1];
  assign run_d     = w_wr_ctrl ? map_wr_dat_i[0] : run_q;

  assign {w_carry, w_acc_sum} = {1'b0, acc_q} + {1'b0, active_inc_q};
  assign w_phase = acc_q + ofs_q;
  // A clear overrides the step, so a carry in that cycle is not a real wrap.
  assign w_wrap  = w_carry && !w_clr;
  assign w_last  = (burst_len_q != '0) && ((burst_cnt_q + DATA_WIDTH'(1)) == burst_len_q);

  // State register
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a run=0 write beats a coincident burst end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (run_d) state_d = S_RUN;
      end
      S_RUN: begin
        if (!run_d)      state_d = S_IDLE;
        else if (w_last) state_d = S_DONE;
      end
      S_DONE: begin
        if (!run_d) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next-value logic
  always_comb begin
    acc_d        = acc_q;
    active_inc_d = active_inc_q;
    wrap_d       = wrap_q;
    burst_cnt_d  = burst_cnt_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    sync_d       = 1'b0;

    if ((state_q == S_IDLE) && (state_d == S_RUN)) begin
      burst_cnt_d = '0;
    end

    if (w_wr_inc && (state_q != S_RUN)) begin
      active_inc_d = PHASE_WIDTH'(map_wr_dat_i);
    end

    if (state_q == S_RUN) begin
      rd_en_d     = 1'b1;
      rd_addr_d   = w_phase[PHASE_WIDTH-1 -: LUT_ADDR_WIDTH];
      sync_d      = wrap_q;
      burst_cnt_d = burst_cnt_q + DATA_WIDTH'(1);
      acc_d       = w_acc_sum;
      wrap_d      = w_wrap;
      // Frequency changes only land at a wrap, keeping the phase continuous.
      if (w_wrap) begin
        active_inc_d = w_wr_inc ? PHASE_WIDTH'(map_wr_dat_i) : pending_inc_q;
      end
    end

    if (w_clr) begin
      acc_d  = '0;
      wrap_d = 1'b0;
    end

    done_d = (state_q == S_DONE) && (state_d == S_DONE) && !rd_en_q;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      run_q         <= 1'b0;
      pending_inc_q <= '0;
      active_inc_q  <= '0;
      ofs_q         <= '0;
      burst_len_q   <= '0;
      burst_cnt_q   <= '0;
      acc_q         <= '0;
      wrap_q        <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      sync_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      run_q         <= run_d;
      active_inc_q  <= active_inc_d;
      burst_cnt_q   <= burst_cnt_d;
      acc_q         <= acc_d;
      wrap_q        <= wrap_d;
      rd_en_q       <= rd_en_d;
      rd_addr_q     <= rd_addr_d;
      sync_q        <= sync_d;
      done_q        <= done_d;
      if (w_wr_inc) pending_inc_q <= PHASE_WIDTH'(map_wr_dat_i);
      if (w_wr_ofs) ofs_q         <= PHASE_WIDTH'(map_wr_dat_i);
      if (w_wr_len) burst_len_q   <= map_wr_dat_i;
    end
  end

  // Return path: memory data is valid the cycle after the read strobe.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rd_pend_q    <= 1'b0;
      wave_q       <= '0;
      wave_valid_q <= 1'b0;
    end else begin
      rd_pend_q    <= rd_en_q;
      wave_valid_q <= rd_pend_q;
      if (rd_pend_q) wave_q <= mem_rd_dat_i;
    end
  end

  assign mem_rd_en_o   = rd_en_q;
  assign mem_rd_addr_o = rd_addr_q;
  assign wave_o        = wave_q;
  assign wave_valid_o  = wave_valid_q;
  assign sync_o        = sync_q;
  assign done_o        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_dds_phase_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dds_phase_gen                                              |
// | Purpose  : Directed self-checking bench for dds_phase_gen.               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_dds_phase_gen;

  logic        clk;
  logic        rst_n;
  logic        map_wr_en_i;
  logic [4:0]  map_wr_addr_i;
  logic [31:0] map_wr_dat_i;
  logic        mem_rd_en_o;
  logic [9:0]  mem_rd_addr_o;
  logic [15:0] mem_rd_dat_i;
  logic [15:0] wave_o;
  logic        wave_valid_o;
  logic        sync_o;
  logic        done_o;

  int n_chk = 0;
  int n_err = 0;
  int n_rd  = 0;
  int n_val = 0;
  int n_sync = 0;
  int cyc   = 0;
  int last_rd_cyc = 0;
  int done_cyc = 0;

  logic [9:0] addr_log [0:1023];
  logic       sync_log [0:1023];
  logic [9:0] rdq [$];

  dds_phase_gen dut (
    .wb_clk_i      (clk),
    .wb_rst_n_i    (rst_n),
    .map_wr_en_i   (map_wr_en_i),
    .map_wr_addr_i (map_wr_addr_i),
    .map_wr_dat_i  (map_wr_dat_i),
    .mem_rd_en_o   (mem_rd_en_o),
    .mem_rd_addr_o (mem_rd_addr_o),
    .mem_rd_dat_i  (mem_rd_dat_i),
    .wave_o        (wave_o),
    .wave_valid_o  (wave_valid_o),
    .sync_o        (sync_o),
    .done_o        (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] lut(input logic [9:0] a);
    return {a, 6'b0} ^ 16'h5A3C;
  endfunction

  // Synchronous wave memory model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)           mem_rd_dat_i <= 16'h0;
    else if (mem_rd_en_o) mem_rd_dat_i <= lut(mem_rd_addr_o);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Read/valid monitor: every sample must match the address read two cycles earlier
  always @(negedge clk) begin
    if (wave_valid_o) begin
      n_val++;
      if (rdq.size() == 0) chk("wave_unexpected", 32'(1), 32'(0));
      else                 chk("wave_data", 32'(wave_o), 32'(lut(rdq.pop_front())));
    end
    if (mem_rd_en_o) begin
      if (n_rd < 1024) begin
        addr_log[n_rd] = mem_rd_addr_o;
        sync_log[n_rd] = sync_o;
      end
      n_rd++;
      if (sync_o) n_sync++;
      last_rd_cyc = cyc;
      rdq.push_back(mem_rd_addr_o);
    end
  end

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    map_wr_en_i   = 1'b1;
    map_wr_addr_i = a;
    map_wr_dat_i  = d;
    @(negedge clk);
    map_wr_en_i   = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rd(input int n, input int budget);
    int k;
    k = 0;
    while (n_rd < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (n_rd < n) chk("timeout_reads", 32'(n_rd), 32'(n));
  endtask

  task automatic wait_addr(input logic [9:0] a, input int budget);
    int k;
    k = 0;
    while (!(mem_rd_en_o && mem_rd_addr_o == a) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) chk("timeout_addr", 32'(mem_rd_addr_o), 32'(a));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"},  32'(mem_rd_en_o),   32'(0));
    chk({tag, "_rd_addr"},32'(mem_rd_addr_o), 32'(0));
    chk({tag, "_wave"},   32'(wave_o),        32'(0));
    chk({tag, "_valid"},  32'(wave_valid_o),  32'(0));
    chk({tag, "_sync"},   32'(sync_o),        32'(0));
    chk({tag, "_done"},   32'(done_o),        32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst_n = 1'b0;
    map_wr_en_i = 1'b0;
    map_wr_addr_i = 5'd0;
    map_wr_dat_i = 32'd0;
    cycles(2);
    chk_all_zero("reset");
    rst_n = 1'b1;
    cycles(2);
    chk("idle_rd_en", 32'(mem_rd_en_o), 32'(0));

    // T1: continuous run, step 4, sync every 256 reads
    wr(5'd1, 32'h0100_0000);
    wr(5'd2, 32'h0);
    n_rd = 0;
    wr(5'd0, 32'h1);
    wait_rd(260, 400);
    chk("t1_a0",   32'(addr_log[0]),   32'h000);
    chk("t1_a1",   32'(addr_log[1]),   32'h004);
    chk("t1_a2",   32'(addr_log[2]),   32'h008);
    chk("t1_a255", 32'(addr_log[255]), 32'h3FC);
    chk("t1_a256", 32'(addr_log[256]), 32'h000);
    chk("t1_s0",   32'(sync_log[0]),   32'(0));
    chk("t1_s255", 32'(sync_log[255]), 32'(0));
    chk("t1_s256", 32'(sync_log[256]), 32'(1));
    wr(5'd0, 32'h0);
    cycles(4);
    chk("t1_stop", 32'(mem_rd_en_o), 32'(0));
    chk("t1_drain", 32'(rdq.size()), 32'(0));

    // T2: mid-run increment change applied only at wrap
    wr(5'd0, 32'h2);
    n_rd = 0;
    wr(5'd0, 32'h1);
    wait_rd(10, 40);
    wr(5'd1, 32'h0200_0000);
    wait_rd(262, 400);
    chk("t2_a100", 32'(addr_log[100]), 32'h190);
    chk("t2_a255", 32'(addr_log[255]), 32'h3FC);
    chk("t2_a256", 32'(addr_log[256]), 32'h000);
    chk("t2_s256", 32'(sync_log[256]), 32'(1));
    chk("t2_a257", 32'(addr_log[257]), 32'h008);
    chk("t2_a258", 32'(addr_log[258]), 32'h010);
    chk("t2_s257", 32'(sync_log[257]), 32'(0));
    wr(5'd0, 32'h0);
    cycles(4);

    // T3: 5-sample burst, done latency, rerun ignored, run=0 clears done
    wr(5'd0, 32'h2);
    wr(5'd1, 32'h0100_0000);
    wr(5'd3, 32'd5);
    n_rd = 0;
    n_val = 0;
    wr(5'd0, 32'h1);
    k = 0;
    while (!done_o && k < 40) begin
      @(negedge clk);
      k++;
    end
    done_cyc = cyc;
    if (k >= 40) chk("t3_done_timeout", 32'(done_o), 32'(1));
    cycles(3);
    chk("t3_reads",   32'(n_rd),  32'(5));
    chk("t3_valids",  32'(n_val), 32'(5));
    chk("t3_done_lat", 32'(done_cyc - last_rd_cyc), 32'(2));
    chk("t3_a4",      32'(addr_log[4]), 32'h010);
    chk("t3_done_hold", 32'(done_o), 32'(1));
    wr(5'd0, 32'h1);
    cycles(5);
    chk("t3_rerun_reads", 32'(n_rd), 32'(5));
    chk("t3_rerun_done",  32'(done_o), 32'(1));
    wr(5'd0, 32'h0);
    chk("t3_done_clr", 32'(done_o), 32'(0));

    // T7: run=0 coinciding with the last burst read
    wr(5'd0, 32'h2);
    wr(5'd3, 32'd3);
    n_rd = 0;
    wr(5'd0, 32'h1);
    wait_addr(10'h004, 20);
    wr(5'd0, 32'h0);
    cycles(5);
    chk("t7_reads", 32'(n_rd), 32'(3));
    chk("t7_done",  32'(done_o), 32'(0));

    // T4: zero increment with half-cycle offset
    wr(5'd3, 32'd0);
    wr(5'd0, 32'h2);
    wr(5'd2, 32'h8000_0000);
    wr(5'd1, 32'h0);
    n_rd = 0;
    n_sync = 0;
    wr(5'd0, 32'h1);
    wait_rd(20, 40);
    wr(5'd0, 32'h0);
    cycles(4);
    chk("t4_a0",   32'(addr_log[0]),  32'h200);
    chk("t4_a19",  32'(addr_log[19]), 32'h200);
    chk("t4_sync", 32'(n_sync), 32'(0));

    // T5: clear while running at address 0x1F0
    wr(5'd2, 32'h0);
    wr(5'd1, 32'h0100_0000);
    wr(5'd0, 32'h2);
    n_rd = 0;
    wr(5'd0, 32'h1);
    wait_addr(10'h1EC, 200);
    wr(5'd0, 32'h3);
    wait_rd(130, 20);
    chk("t5_a124", 32'(addr_log[124]), 32'h1F0);
    chk("t5_a125", 32'(addr_log[125]), 32'h000);
    chk("t5_a126", 32'(addr_log[126]), 32'h004);
    chk("t5_s125", 32'(sync_log[125]), 32'(0));
    wr(5'd0, 32'h0);
    cycles(4);

    // T6: asynchronous reset mid-burst
    wr(5'd3, 32'd100);
    wr(5'd0, 32'h2);
    n_rd = 0;
    wr(5'd0, 32'h1);
    wait_rd(10, 40);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    rdq.delete();
    n_rd = 0;
    cycles(20);
    chk("t6_no_reads", 32'(n_rd), 32'(0));
    chk("t6_done",     32'(done_o), 32'(0));
    wr(5'd0, 32'h1);
    wait_rd(5, 20);
    chk("t6_restart", 32'(n_rd >= 5), 32'(1));
    chk("t6_addr0",   32'(addr_log[0]), 32'h000);
    wr(5'd0, 32'h0);
    cycles(4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
